// File: rtl/depth_buffer_writer.sv
// Depth-tested fragment writer: read-modify-write against an external z-buffer
// BRAM, plus a full-screen clear sequencer for the z-buffer and colour framebuffer.
module depth_buffer_writer #(
    parameter int          H_RES        = 320,
    parameter int          V_RES        = 240,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] CLEAR_Z      = 16'hFFFF,
    parameter logic [11:0] CLEAR_RGB    = 12'h000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [8:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [15:0] z_in,
    input  logic [11:0] rgb_in,
    input  logic        clear_in,
    output logic        busy_out,
    output logic [16:0] zbuf_raddr_out,
    input  logic [15:0] zbuf_rdata_in,
    output logic        zbuf_we_out,
    output logic [16:0] zbuf_waddr_out,
    output logic [15:0] zbuf_wdata_out,
    output logic        fb_we_out,
    output logic [16:0] fb_waddr_out,
    output logic [11:0] fb_wdata_out,
    output logic [16:0] drawn_count_out
);

    localparam int          NSTG     = READ_LATENCY + 1;
    localparam logic [16:0] END_ADDR = 17'(H_RES * V_RES);
    localparam logic [31:0] H_LIM    = 32'(H_RES);
    localparam logic [31:0] V_LIM    = 32'(V_RES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        return ({9'd0, y} * 17'(H_RES)) + {8'd0, x};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [16:0] clr_addr_q, clr_addr_d;
    logic [16:0] count_q, count_d;
    logic        we_q, we_d;
    logic [16:0] waddr_q, waddr_d;
    logic [15:0] zw_q, zw_d;
    logic [11:0] rgbw_q, rgbw_d;
    logic [16:0] raddr_q;

    logic [NSTG-1:0] vld_q;
    logic [16:0]     addr_q [NSTG];
    logic [15:0]     z_q    [NSTG];
    logic [11:0]     rgb_q  [NSTG];
    logic [15:0]     zold_q;

    logic        in_range, hazard, pipe_busy, accept, take, pass;
    logic [16:0] in_addr;

    assign in_addr   = pix_addr(x_in, y_in);
    assign in_range  = ({23'd0, x_in} < H_LIM) && ({24'd0, y_in} < V_LIM);
    assign pipe_busy = |vld_q;

    // Only stages that have not yet reached the write register block a same-address
    // fragment; once the write is registered the BRAM holds the new z before the next read.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            if (vld_q[k] && (addr_q[k] == in_addr)) hazard = 1'b1;
        end
    end

    assign ready_out = !rst_in && (state_q == ST_IDLE) && !(in_range && hazard);
    assign accept    = valid_in && ready_out;
    assign take      = accept && in_range;
    assign pass      = vld_q[NSTG-1] && (z_q[NSTG-1] < zold_q);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        zw_d       = zw_q;
        rgbw_d     = rgbw_q;

        if (pass) begin
            we_d    = 1'b1;
            waddr_d = addr_q[NSTG-1];
            zw_d    = z_q[NSTG-1];
            rgbw_d  = rgb_q[NSTG-1];
            count_d = count_q + 17'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d    = ST_CLEAR;
                    we_d       = 1'b1;
                    waddr_d    = 17'd0;
                    zw_d       = CLEAR_Z;
                    rgbw_d     = CLEAR_RGB;
                    clr_addr_d = 17'd1;
                    count_d    = 17'd0;
                end
            end
            ST_CLEAR: begin
                // Leave one cycle after the final write so busy covers it.
                if (clr_addr_q == END_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d       = 1'b1;
                    waddr_d    = clr_addr_q;
                    zw_d       = CLEAR_Z;
                    rgbw_d     = CLEAR_RGB;
                    clr_addr_d = clr_addr_q + 17'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= 17'd0;
            count_q    <= 17'd0;
            we_q       <= 1'b0;
            waddr_q    <= 17'd0;
            zw_q       <= 16'd0;
            rgbw_q     <= 12'd0;
            raddr_q    <= 17'd0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            zw_q       <= zw_d;
            rgbw_q     <= rgbw_d;
            if (take) raddr_q <= in_addr;
            vld_q      <= {vld_q[NSTG-2:0], take};
        end
    end

    // Fragment data pipeline; the last stage pairs with the z read back from BRAM
    always_ff @(posedge clk_in) begin
        if (take) begin
            addr_q[0] <= in_addr;
            z_q[0]    <= z_in;
            rgb_q[0]  <= rgb_in;
        end
        for (int k = 1; k < NSTG; k++) begin
            addr_q[k] <= addr_q[k-1];
            z_q[k]    <= z_q[k-1];
            rgb_q[k]  <= rgb_q[k-1];
        end
        zold_q <= zbuf_rdata_in;
    end

    assign busy_out        = (state_q != ST_IDLE);
    assign zbuf_raddr_out  = raddr_q;
    assign zbuf_we_out     = we_q;
    assign zbuf_waddr_out  = waddr_q;
    assign zbuf_wdata_out  = zw_q;
    assign fb_we_out       = we_q;
    assign fb_waddr_out    = waddr_q;
    assign fb_wdata_out    = rgbw_q;
    assign drawn_count_out = count_q;

endmodule
